fft_frame_reader: RTL and testbench

- Read side of the ping-pong sample buffer.
- On each buffer-full pulse, sweeps the read address over the completed buffer and streams the frame to the FFT core.
- Output interface is valid/ready with an end-of-frame marker.
- Detects frames arriving faster than the FFT drains them: pulses an overrun flag and counts dropped frames.

---
 rtl/fft_frame_reader.sv | 142 ++++++++++++++
 tb/tb_fft_frame_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_reader.sv
// Read side of the ping-pong sample buffer: streams a completed frame to the FFT core over valid/ready.
// Define FFT_READER_BITREV_EN to read the buffer in bit-reversed address order.
module fft_frame_reader #(
    parameter int DATA_WIDTH   = 24,
    parameter int BUFFER_DEPTH = 512,
    parameter int ADDR_WIDTH   = $clog2(BUFFER_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_fft_data_ready,
    output logic [ADDR_WIDTH-1:0] o_fft_read_addr,
    input  logic [DATA_WIDTH-1:0] i_fft_data_out,
    output logic [DATA_WIDTH-1:0] o_sample_data,
    output logic                  o_sample_valid,
    input  logic                  i_sample_ready,
    output logic                  o_sample_last,
    output logic                  o_frame_done,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic [7:0]            o_drop_count
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            drop_q, drop_d;

    logic xfer, load, cnt_last;

    assign xfer     = valid_q && i_sample_ready;
    assign load     = (state_q == STREAM) && (!valid_q || i_sample_ready);
    assign cnt_last = (cnt_q == ADDR_WIDTH'(BUFFER_DEPTH - 1));

`ifdef FFT_READER_BITREV_EN
    always_comb begin
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            o_fft_read_addr[i] = cnt_q[ADDR_WIDTH-1-i];
        end
    end
`else
    assign o_fft_read_addr = cnt_q;
`endif

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        drop_d    = drop_q;

        // A frame landing while one is already queued overwrites it: the queued one is lost.
        if (i_fft_data_ready && state_q != IDLE) begin
            if (pending_q) begin
                overrun_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (i_fft_data_ready || pending_q) begin
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (load) begin
                    data_d  = i_fft_data_out;
                    valid_d = 1'b1;
                    last_d  = cnt_last;
                    cnt_d   = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    // A frame arriving on this very cycle restarts directly rather than counting as overrun.
                    if (pending_q || i_fft_data_ready) begin
                        state_d   = STREAM;
                        cnt_d     = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    assign o_sample_data  = data_q;
    assign o_sample_valid = valid_q;
    assign o_sample_last  = last_q;
    assign o_frame_done   = done_q;
    assign o_busy         = (state_q != IDLE);
    assign o_overrun      = overrun_q;
    assign o_drop_count   = drop_q;

endmodule

// File: tb/tb_fft_frame_reader.sv
// Directed bench for fft_frame_reader: buffer model returns addr+1, a negedge monitor checks the stream.
// Build with FFT_READER_BITREV_EN to exercise the bit-reversed order at depth 8.
module tb_fft_frame_reader;

`ifdef FFT_READER_BITREV_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 512;
`endif
    localparam int DW = 24;
    localparam int AW = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          i_fft_data_ready;
    logic [AW-1:0] o_fft_read_addr;
    logic [DW-1:0] i_fft_data_out;
    logic [DW-1:0] o_sample_data;
    logic          o_sample_valid;
    logic          i_sample_ready;
    logic          o_sample_last;
    logic          o_frame_done;
    logic          o_busy;
    logic          o_overrun;
    logic [7:0]    o_drop_count;

    always #5 clk = ~clk;

    fft_frame_reader #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_fft_data_ready (i_fft_data_ready),
        .o_fft_read_addr  (o_fft_read_addr),
        .i_fft_data_out   (i_fft_data_out),
        .o_sample_data    (o_sample_data),
        .o_sample_valid   (o_sample_valid),
        .i_sample_ready   (i_sample_ready),
        .o_sample_last    (o_sample_last),
        .o_frame_done     (o_frame_done),
        .o_busy           (o_busy),
        .o_overrun        (o_overrun),
        .o_drop_count     (o_drop_count)
    );

    always_comb i_fft_data_out = DW'(o_fft_read_addr) + DW'(1);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected sample at frame position pos: natural order, or bit-reversed address, plus one.
    function automatic logic [DW-1:0] exp_data(input int pos);
        logic [AW-1:0] a, r;
        a = AW'(pos);
`ifdef FFT_READER_BITREV_EN
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
`else
        r = a;
`endif
        return DW'(r) + DW'(1);
    endfunction

    // Stream monitor: transfers happen at the next posedge iff valid && ready here.
    int          pos = 0, xfers = 0, done_cnt = 0, ov_cnt = 0, mon_err = 0;
    int          cyc = 0, frame_first_cyc = 0, last_xfer_cyc = 0;
    bit          prev_stall = 0, prev_last = 0;
    logic [DW-1:0] held_data;
    logic        held_last;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            pos        = 0;
            prev_stall = 0;
            prev_last  = 0;
        end else begin
            if (o_frame_done !== prev_last) begin
                mon_err++;
                $display("[MON] frame_done=%0b at cycle %0d, expected %0b", o_frame_done, cyc, prev_last);
            end
            if (o_frame_done) done_cnt++;
            if (o_overrun) ov_cnt++;
            if (o_sample_last && !o_sample_valid) mon_err++;
            if (prev_stall && (o_sample_data !== held_data || o_sample_last !== held_last || !o_sample_valid)) begin
                mon_err++;
                $display("[MON] output changed during stall at cycle %0d", cyc);
            end
            prev_last = 0;
            if (o_sample_valid && i_sample_ready) begin
                if (o_sample_data !== exp_data(pos) || o_sample_last !== (pos == DEPTH - 1)) begin
                    mon_err++;
                    $display("[MON] pos %0d: data %0d last %0b, expected %0d %0b",
                             pos, o_sample_data, o_sample_last, exp_data(pos), (pos == DEPTH - 1));
                end
                if (pos == 0) frame_first_cyc = cyc;
                last_xfer_cyc = cyc;
                prev_last     = (pos == DEPTH - 1);
                pos           = (pos == DEPTH - 1) ? 0 : pos + 1;
                xfers++;
            end
            prev_stall = o_sample_valid && !i_sample_ready;
            held_data  = o_sample_data;
            held_last  = o_sample_last;
        end
    end

    typedef struct {
        string name;
        int    ready_mode;   // 0: ready held high, 1: ready toggles every cycle
        int    n_pulses;     // extra buffer-full pulses during the first frame
        int    pulse_at;     // transfer count of the first extra pulse
        int    exp_frames;
        int    exp_overruns;
        int    exp_drop;     // absolute o_drop_count afterwards
    } vec_t;

    localparam int P100    = DEPTH * 100 / 512;
    localparam int P300    = DEPTH * 300 / 512;
    localparam int SPACING = (DEPTH / 8 > 0) ? DEPTH / 8 : 1;

    task automatic run_scenario(input vec_t v);
        int  b_x = xfers, b_d = done_cnt, b_o = ov_cnt, b_e = mon_err;
        int  next = 0;
        int  budget = v.exp_frames * DEPTH * 3 + 50;
        bit  rdy = 1'b1;
        bit  finished = 1'b0;
        @(posedge clk); #1;
        i_fft_data_ready = 1'b1;
        i_sample_ready   = 1'b1;
        for (int c = 0; c < budget && !finished; c++) begin
            @(posedge clk); #1;
            i_fft_data_ready = 1'b0;
            if (v.ready_mode == 1) rdy = !rdy;
            i_sample_ready = rdy;
            if (next < v.n_pulses && xfers - b_x >= v.pulse_at + next * SPACING) begin
                i_fft_data_ready = 1'b1;
                next++;
            end
            if (done_cnt - b_d >= v.exp_frames && !o_busy && next >= v.n_pulses) finished = 1'b1;
        end
        check({v.name, " completes in budget"}, finished, 1'b1);
        i_fft_data_ready = 1'b0;
        i_sample_ready   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({v.name, " frame_done pulses"}, done_cnt - b_d, v.exp_frames);
        check({v.name, " transfers"}, xfers - b_x, v.exp_frames * DEPTH);
        check({v.name, " overrun pulses"}, ov_cnt - b_o, v.exp_overruns);
        check({v.name, " drop_count"}, o_drop_count, v.exp_drop);
        check({v.name, " busy low after"}, o_busy, 1'b0);
        check({v.name, " valid low after"}, o_sample_valid, 1'b0);
        check({v.name, " stream errors"}, mon_err - b_e, 0);
        if (v.ready_mode == 0)
            check({v.name, " one sample per cycle"}, last_xfer_cyc - frame_first_cyc, DEPTH - 1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"full_rate",      0, 0, 0,    1, 0, 0};
        vecs[1] = '{"toggle_ready",   1, 0, 0,    1, 0, 0};
        vecs[2] = '{"queued_full",    0, 1, P100, 2, 0, 0};
        vecs[3] = '{"queued_toggle",  1, 1, P100, 2, 0, 0};
        vecs[4] = '{"overrun_full",   0, 3, P100, 2, 2, 2};
        vecs[5] = '{"overrun_toggle", 1, 3, P100, 2, 2, 4};

        reset            = 1'b0;
        i_fft_data_ready = 1'b0;
        i_sample_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid", o_sample_valid, 1'b0);
        check("reset busy", o_busy, 1'b0);
        check("reset drop_count", o_drop_count, 8'd0);
        check("reset addr", o_fft_read_addr, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // First valid two cycles after the buffer-full pulse.
        @(posedge clk); #1;
        i_fft_data_ready = 1'b1;
        i_sample_ready   = 1'b1;
        @(posedge clk); #1;
        i_fft_data_ready = 1'b0;
        @(negedge clk);
        check("latency busy", o_busy, 1'b1);
        check("latency valid early", o_sample_valid, 1'b0);
        @(negedge clk);
        check("latency valid", o_sample_valid, 1'b1);
        check("latency first data", o_sample_data, exp_data(0));
        begin
            bit ok = 1'b0;
            for (int c = 0; c < DEPTH * 2 && !ok; c++) begin
                @(negedge clk);
                if (!o_busy && done_cnt == 1) ok = 1'b1;
            end
            check("latency frame completes", ok, 1'b1);
        end

        foreach (vecs[i]) run_scenario(vecs[i]);

        // Reset mid-frame: partial frame abandoned, no frame_done, counters cleared.
        begin
            int b_x = xfers;
            int b_d;
            bit hit = 1'b0;
            @(posedge clk); #1;
            i_fft_data_ready = 1'b1;
            i_sample_ready   = 1'b1;
            for (int c = 0; c < DEPTH * 2 && !hit; c++) begin
                @(posedge clk); #1;
                i_fft_data_ready = 1'b0;
                if (xfers - b_x >= P300) hit = 1'b1;
            end
            check("midreset reached transfer", hit, 1'b1);
            b_d   = done_cnt;
            reset = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("midreset valid", o_sample_valid, 1'b0);
            check("midreset last", o_sample_last, 1'b0);
            check("midreset data", o_sample_data, 0);
            check("midreset busy", o_busy, 1'b0);
            check("midreset done", o_frame_done, 1'b0);
            check("midreset overrun", o_overrun, 1'b0);
            check("midreset drop_count", o_drop_count, 8'd0);
            check("midreset addr", o_fft_read_addr, 0);
            @(posedge clk); #1;
            reset = 1'b1;
            repeat (5) @(posedge clk);
            @(negedge clk);
            check("midreset no frame_done", done_cnt - b_d, 0);
            check("midreset idle", o_busy, 1'b0);
        end
        run_scenario('{"after_reset", 0, 0, 0, 1, 0, 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
